// File: rtl/spi_cfg_sequencer.sv
// Table-driven register-bus sequencer: fetches commands from a synchronous ROM and issues
// writes, reads, bit-polls and waits. Optional poll timeout: define SPI_CFG_POLL_TIMEOUT_EN.
module spi_cfg_sequencer #(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 8,
  parameter int unsigned PTR_W       = 5,
  parameter int unsigned START_DELAY = 500,
  parameter int unsigned AUTO_START  = 1,
  parameter int unsigned POLL_LIMIT  = 1024
) (
  input  logic                 clk,
  input  logic                 readyreset,
  input  logic                 start_i,
  output logic [PTR_W-1:0]     cmd_ptr_o,
  input  logic [3+AW+DW-1:0]   cmd_word_i,
  output logic                 bus_cs_o,
  output logic                 bus_we_o,
  output logic [AW-1:0]        bus_addr_o,
  output logic [DW-1:0]        bus_wdata_o,
  input  logic [DW-1:0]        bus_rdata_i,
  input  logic                 bus_rdy_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [DW-1:0]        last_rdata_o
);

  localparam int unsigned DlyW = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StReq, StGap, StWaitc, StDone, StError
  } state_e;

  typedef enum logic [2:0] {
    OpWrite, OpRead, OpPollSet, OpPollClr, OpWait, OpJump, OpEnd, OpIllegal
  } op_e;

  state_e            state_q;
  op_e               op_q;
  logic [PTR_W-1:0]  cmd_ptr_q;
  logic              bus_cs_q, bus_we_q;
  logic [AW-1:0]     bus_addr_q;
  logic [DW-1:0]     bus_wdata_q;
  logic              busy_q, done_q, error_q;
  logic [DW-1:0]     last_rdata_q;
  logic [DW-1:0]     data_q;
  logic [DW-1:0]     wait_q;
  logic [DlyW-1:0]   dly_q;
  logic              auto_pend_q;

  op_e               cmd_op;
  logic [AW-1:0]     cmd_addr;
  logic [DW-1:0]     cmd_data;
  logic              auto_fire;
  logic              is_poll;
  logic              poll_met;
  logic              poll_give_up;

  assign cmd_op   = op_e'(cmd_word_i[3+AW+DW-1 -: 3]);
  assign cmd_addr = cmd_word_i[AW+DW-1 -: AW];
  assign cmd_data = cmd_word_i[DW-1:0];

  // The auto-start request stays pending from reset until the first launch of any kind.
  assign auto_fire = auto_pend_q && (dly_q == DlyW'(START_DELAY));
  assign is_poll   = (op_q == OpPollSet) || (op_q == OpPollClr);
  assign poll_met  = (op_q == OpPollSet) ? |(last_rdata_q & data_q) : ~|(last_rdata_q & data_q);

`ifdef SPI_CFG_POLL_TIMEOUT_EN
  localparam int unsigned PcW = $clog2(POLL_LIMIT + 1);

  logic [PcW-1:0] poll_cnt_q;

  assign poll_give_up = (poll_cnt_q == PcW'(POLL_LIMIT));

  always_ff @(posedge clk or posedge readyreset) begin
    if (readyreset) begin
      poll_cnt_q <= '0;
    end else if (state_q == StDecode) begin
      poll_cnt_q <= '0;
    end else if ((state_q == StReq) && bus_rdy_i && !poll_give_up) begin
      poll_cnt_q <= poll_cnt_q + 1'b1;
    end
  end
`else
  assign poll_give_up = 1'b0;

  if (POLL_LIMIT == 0) begin : g_poll_limit_chk
    $error("POLL_LIMIT must be nonzero");
  end
`endif

  always_ff @(posedge clk or posedge readyreset) begin
    if (readyreset) begin
      state_q      <= StIdle;
      op_q         <= OpWrite;
      cmd_ptr_q    <= '0;
      bus_cs_q     <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      last_rdata_q <= '0;
      data_q       <= '0;
      wait_q       <= '0;
      dly_q        <= '0;
      auto_pend_q  <= (AUTO_START != 0);
    end else begin
      if (auto_pend_q && !auto_fire) begin
        dly_q <= dly_q + 1'b1;
      end
      case (state_q)
        StIdle, StDone, StError: begin
          if (start_i || auto_fire) begin
            state_q     <= StFetch;
            cmd_ptr_q   <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            auto_pend_q <= 1'b0;
          end
        end
        StFetch: state_q <= StDecode;
        StDecode: begin
          op_q   <= cmd_op;
          data_q <= cmd_data;
          case (cmd_op)
            OpWrite, OpRead, OpPollSet, OpPollClr: begin
              bus_we_q    <= (cmd_op == OpWrite);
              bus_addr_q  <= cmd_addr;
              bus_wdata_q <= cmd_data;
              bus_cs_q    <= 1'b1;
              state_q     <= StReq;
            end
            OpWait: begin
              wait_q  <= cmd_data;
              state_q <= StWaitc;
            end
            OpJump: begin
              cmd_ptr_q <= cmd_data[PTR_W-1:0];
              state_q   <= StFetch;
            end
            OpEnd: begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end
            default: begin
              busy_q  <= 1'b0;
              error_q <= 1'b1;
              state_q <= StError;
            end
          endcase
        end
        StReq: begin
          if (bus_rdy_i) begin
            bus_cs_q <= 1'b0;
            state_q  <= StGap;
            if (!bus_we_q) begin
              last_rdata_q <= bus_rdata_i;
            end
          end
        end
        // One idle bus cycle between requests; an unmet poll re-reads the same command.
        StGap: begin
          if (is_poll && !poll_met) begin
            if (poll_give_up) begin
              busy_q  <= 1'b0;
              error_q <= 1'b1;
              state_q <= StError;
            end else begin
              bus_cs_q <= 1'b1;
              state_q  <= StReq;
            end
          end else begin
            cmd_ptr_q <= cmd_ptr_q + 1'b1;
            state_q   <= StFetch;
          end
        end
        StWaitc: begin
          if (wait_q == '0) begin
            cmd_ptr_q <= cmd_ptr_q + 1'b1;
            state_q   <= StFetch;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ptr_o    = cmd_ptr_q;
  assign bus_cs_o     = bus_cs_q;
  assign bus_we_o     = bus_we_q;
  assign bus_addr_o   = bus_addr_q;
  assign bus_wdata_o  = bus_wdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign last_rdata_o = last_rdata_q;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Self-checking bench for spi_cfg_sequencer: a ROM-program interpreter predicts the bus
// transaction list and final status; a per-cycle monitor checks the DUT against it.
module tb_spi_cfg_sequencer;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned PW = 5;
  localparam int unsigned SD = 20;
  localparam int unsigned PL = 4;
  localparam int unsigned CW = 3 + AW + DW;

  logic          clk = 1'b0;
  logic          readyreset = 1'b1;
  logic          start = 1'b0;
  logic [PW-1:0] cmd_ptr;
  logic [CW-1:0] cmd_word = '0;
  logic          bus_cs, bus_we, bus_rdy;
  logic [7:0]    bus_addr, bus_wdata, bus_rdata, last_rdata;
  logic          busy, done, error;

  always #5 clk = ~clk;

  spi_cfg_sequencer #(
    .AW(AW), .DW(DW), .PTR_W(PW), .START_DELAY(SD), .AUTO_START(1), .POLL_LIMIT(PL)
  ) dut (
    .clk(clk), .readyreset(readyreset), .start_i(start), .cmd_ptr_o(cmd_ptr),
    .cmd_word_i(cmd_word), .bus_cs_o(bus_cs), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata), .bus_rdy_i(bus_rdy), .busy_o(busy),
    .done_o(done), .error_o(error), .last_rdata_o(last_rdata)
  );

  logic [CW-1:0] rom [32];
  always @(posedge clk) cmd_word <= rom[cmd_ptr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] mk(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] d);
    return {op, a, d};
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct { bit we; logic [7:0] addr; logic [7:0] wd; logic [7:0] rd; } txn_t;
  txn_t       exp_q[$];
  int         exp_end;   // 1 = done, 2 = error
  int         exp_ptr;
  logic [7:0] exp_last = 8'h00;
  logic [7:0] rd_vals[$];
  int         rd_idx;

  function automatic logic [7:0] rd_at(input int i);
    return (i < rd_vals.size()) ? rd_vals[i] : 8'h00;
  endfunction

  task automatic build_expect(input int cap);
    int ptr = 0;
    int ri = 0;
    int steps = 0;
    logic [2:0] op;
    logic [7:0] a, d, r;
    txn_t t;
    exp_q.delete();
    exp_end = 0;
    exp_ptr = 0;
    while (exp_q.size() < cap && steps < 2000) begin
      steps++;
      {op, a, d} = rom[ptr];
      case (op)
        3'd0: begin
          t = '{we: 1'b1, addr: a, wd: d, rd: 8'h00};
          exp_q.push_back(t);
          ptr = (ptr + 1) % 32;
        end
        3'd1: begin
          r = rd_at(ri); ri++;
          t = '{we: 1'b0, addr: a, wd: d, rd: r};
          exp_q.push_back(t);
          exp_last = r;
          ptr = (ptr + 1) % 32;
        end
        3'd2, 3'd3: begin
          int n = 0;
          bit met = 0;
          bit to = 0;
          while (!met && !to && exp_q.size() < cap) begin
            r = rd_at(ri); ri++; n++;
            t = '{we: 1'b0, addr: a, wd: d, rd: r};
            exp_q.push_back(t);
            exp_last = r;
            met = (op == 3'd2) ? ((r & d) != 0) : ((r & d) == 0);
`ifdef SPI_CFG_POLL_TIMEOUT_EN
            if (!met && n == PL) to = 1;
`endif
          end
          if (to) begin
            exp_end = 2; exp_ptr = ptr;
            return;
          end
          if (met) ptr = (ptr + 1) % 32;
        end
        3'd4: ptr = (ptr + 1) % 32;
        3'd5: ptr = d % 32;
        3'd6: begin exp_end = 1; exp_ptr = ptr; return; end
        default: begin exp_end = 2; exp_ptr = ptr; return; end
      endcase
    end
  endtask

  // ---------------- bus slave ----------------
  int lat = 3;
  bit noise = 0;
  initial begin
    int s_cnt = 0;
    bit s_done = 0;
    bus_rdy = 1'b0;
    bus_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (bus_cs && !s_done) begin
        if (s_cnt == lat) begin
          bus_rdy = 1'b1;
          bus_rdata = rd_at(rd_idx);
          if (!bus_we) rd_idx++;
          s_done = 1;
        end else begin
          bus_rdy = 1'b0;
          bus_rdata = 8'($urandom);
        end
        s_cnt++;
      end else if (bus_cs) begin
        bus_rdy = 1'b0;
      end else begin
        s_cnt = 0;
        s_done = 0;
        bus_rdy = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_rdata = 8'($urandom);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int   txn_idx = 0;
  int   rise_t[$];
  bit   allow_extra = 0;
  bit   hold_busy = 0;
  bit   mon_en = 0;

  initial begin
    logic       cs_prev = 0, hs_prev = 0, rd_pend = 0;
    logic [7:0] pend_rd = 0, h_addr = 0, h_wd = 0;
    logic       h_we = 0;
    forever begin
      @(negedge clk);
      if (readyreset) begin
        cs_prev = 0; hs_prev = 0; rd_pend = 0;
      end else if (mon_en) begin
        if (rd_pend) chk("last_rdata_after_read", last_rdata, pend_rd);
        rd_pend = 0;
        if (hs_prev) chk("gap_after_rdy", bus_cs, 1'b0);
        if (bus_cs && !cs_prev) begin
          rise_t.push_back(cyc);
          if (txn_idx < exp_q.size()) begin
            chk("txn_we", bus_we, exp_q[txn_idx].we);
            chk("txn_addr", bus_addr, exp_q[txn_idx].addr);
            if (exp_q[txn_idx].we) chk("txn_wdata", bus_wdata, exp_q[txn_idx].wd);
          end else if (!allow_extra) begin
            chk("extra_txn", txn_idx, exp_q.size());
          end
          txn_idx++;
          h_we = bus_we; h_addr = bus_addr; h_wd = bus_wdata;
        end else if (bus_cs) begin
          chk("cs_stable_we", bus_we, h_we);
          chk("cs_stable_addr", bus_addr, h_addr);
          chk("cs_stable_wdata", bus_wdata, h_wd);
        end
        if (bus_cs && bus_rdy && !bus_we && (txn_idx - 1) < exp_q.size()) begin
          rd_pend = 1;
          pend_rd = exp_q[txn_idx - 1].rd;
        end
        hs_prev = bus_cs && bus_rdy;
        if (error) chk("cs_low_in_error", bus_cs, 1'b0);
        chk("busy_exclusive", busy & (done | error), 1'b0);
        if (hold_busy) chk("busy_held", busy, 1'b1);
        cs_prev = bus_cs;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic fill_end();
    for (int i = 0; i < 32; i++) rom[i] = mk(3'd6, 8'h00, 8'h00);
  endtask

  task automatic load_t1();
    fill_end();
    rom[0] = mk(3'd0, 8'h84, 8'h09);
    rom[1] = mk(3'd0, 8'hC0, 8'h0A);
    rom[2] = mk(3'd6, 8'h00, 8'h00);
  endtask

  task automatic arm(input bit extra);
    txn_idx = 0;
    rise_t.delete();
    rd_idx = 0;
    allow_extra = extra;
    mon_en = 1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_end(input int max_cyc);
    int n = 0;
    while (!(done || error) && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    chk("end_reached", done | error, 1'b1);
  endtask

  task automatic end_checks();
    chk("done_flag", done, exp_end == 1);
    chk("error_flag", error, exp_end == 2);
    chk("busy_at_end", busy, 1'b0);
    chk("cs_at_end", bus_cs, 1'b0);
    chk("cmd_ptr_at_end", cmd_ptr, exp_ptr);
    chk("txn_count", txn_idx, exp_q.size());
    chk("last_rdata_at_end", last_rdata, exp_last);
  endtask

  function automatic int rise_gap(input int i, input int j);
    return (rise_t.size() > j) ? (rise_t[j] - rise_t[i]) : -1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int t0, n;
    load_t1();
    readyreset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ptr", cmd_ptr, 0);
    chk("rst_bus_cs", bus_cs, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_last_rdata", last_rdata, 0);

    // Auto-start, two writes then END.
    build_expect(64);
    chk("model_t1_size", exp_q.size(), 2);
    chk("model_t1_ptr", exp_ptr, 2);
    arm(0);
    @(negedge clk);
    t0 = cyc;
    readyreset = 1'b0;
    wait_end(400);
    end_checks();
    chk("t1_done_ptr", cmd_ptr, 2);
    // release, SD+1 edges to FETCH, then DECODE, then REQ
    chk("t1_autostart_lat", (rise_t.size() > 0) ? rise_t[0] - t0 : -1, SD + 3);
    // REQ(3+1) + GAP + FETCH + DECODE
    chk("t1_write_spacing", rise_gap(0, 1), 7);

    // Poll-set with two misses, WAIT 5, write; bus noise while cs is low.
    fill_end();
    rom[0] = mk(3'd2, 8'h0C, 8'h10);
    rom[1] = mk(3'd4, 8'h00, 8'h05);
    rom[2] = mk(3'd0, 8'h21, 8'h5A);
    rd_vals = '{8'h00, 8'h00, 8'h10};
    noise = 1;
    build_expect(64);
    chk("model_t2_size", exp_q.size(), 4);
    arm(0);
    pulse_start();
    chk("t2_start_busy", busy, 1);
    chk("t2_start_done_clr", done, 0);
    chk("t2_start_ptr", cmd_ptr, 0);
    wait_end(400);
    end_checks();
    noise = 0;
    chk("t2_last_rdata", last_rdata, 8'h10);
    chk("t2_poll_respacing", rise_gap(0, 1), 5);
    chk("t2_wait_span", rise_gap(2, 3), 15);

    // Endless JUMP loop with start pulses while busy.
    fill_end();
    rom[0] = mk(3'd0, 8'h10, 8'hAA);
    rom[1] = mk(3'd3, 8'h11, 8'h01);
    rom[2] = mk(3'd5, 8'h00, 8'h00);
    rd_vals.delete();
    for (int i = 0; i < 20; i++) begin
      rd_vals.push_back(8'h01);
      rd_vals.push_back(8'h00);
    end
    lat = 1;
    noise = 1;
    build_expect(40);
    arm(1);
    pulse_start();
    hold_busy = 1;
    n = 0;
    while (txn_idx < 15 && n < 600) begin
      @(posedge clk); #1;
      start = (n % 5 == 2);
      n++;
    end
    start = 1'b0;
    noise = 0;
    chk("t3_loop_progress", txn_idx >= 15, 1);
    chk("t3_busy", busy, 1);

    // Reset while a request is outstanding.
    n = 0;
    while (!bus_cs && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_cs_before_reset", bus_cs, 1);
    hold_busy = 0;
    #2 readyreset = 1'b1;
    #1;
    chk("t5_cs_async", bus_cs, 0);
    chk("t5_busy_async", busy, 0);
    chk("t5_ptr_async", cmd_ptr, 0);
    chk("t5_addr_async", bus_addr, 0);
    exp_last = 8'h00;
    load_t1();
    rd_vals.delete();
    lat = 3;
    build_expect(64);
    arm(0);
    @(negedge clk);
    t0 = cyc;
    readyreset = 1'b0;
    wait_end(400);
    end_checks();
    chk("t5_autostart_lat", (rise_t.size() > 0) ? rise_t[0] - t0 : -1, SD + 3);

    // Illegal opcode at index 3, then a restart.
    fill_end();
    rom[0] = mk(3'd0, 8'h05, 8'h11);
    rom[1] = mk(3'd4, 8'h00, 8'h02);
    rom[2] = mk(3'd1, 8'h30, 8'h00);
    rom[3] = mk(3'd7, 8'h00, 8'h00);
    rd_vals = '{8'h77};
    build_expect(64);
    chk("model_t6_ptr", exp_ptr, 3);
    arm(0);
    pulse_start();
    wait_end(400);
    end_checks();
    chk("t6_error", error, 1);
    chk("t6_ptr", cmd_ptr, 3);
    chk("t6_txns", txn_idx, 2);
    build_expect(64);
    arm(0);
    pulse_start();
    chk("t6_restart_err_clr", error, 0);
    chk("t6_restart_busy", busy, 1);
    chk("t6_restart_ptr", cmd_ptr, 0);
    wait_end(400);
    end_checks();

`ifdef SPI_CFG_POLL_TIMEOUT_EN
    // Poll whose bit never sets.
    fill_end();
    rom[0] = mk(3'd0, 8'h02, 8'h03);
    rom[1] = mk(3'd2, 8'h40, 8'h80);
    rd_vals.delete();
    lat = 2;
    build_expect(64);
    chk("model_t4_size", exp_q.size(), 5);
    arm(0);
    pulse_start();
    wait_end(400);
    end_checks();
    chk("t4_error", error, 1);
    chk("t4_ptr", cmd_ptr, 1);
    chk("t4_txns", txn_idx, 1 + PL);
`endif

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
